dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the core load/store unit (port C) and the debug/trace read port (port D).
- Sits between the core datapath and the data memory, so the bench can read memory contents while the core runs.
- Core has priority; a starvation counter forces a debug grant after a bounded wait.
- One transaction outstanding at a time, with variable memory response latency.

Parameters:
- XLEN, riscv_pkg::XLEN (32), address/data width.
- STARVE_LIMIT, 4, cycles D may wait with a pending request before it wins over C (legal range 1..255).

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- c_req_i  in  1  core request valid
- c_we_i  in  1  core write enable
- c_addr_i  in  XLEN  core byte address
- c_wdata_i  in  XLEN  core write data
- c_be_i  in  4  core byte enables
- c_gnt_o  out  1  core request accepted this cycle
- c_rvalid_o  out  1  core response valid (read data or write ack)
- c_rdata_o  out  XLEN  core read data
- d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i  in  1/1/XLEN/XLEN/4  debug request, same meaning as the core port
- d_gnt_o, d_rvalid_o  out  1/1  debug grant and response valid
- d_rdata_o  out  XLEN  debug read data
- mem_req_o  out  1  memory request
- mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o  out  1/XLEN/XLEN/4  muxed request fields
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  XLEN  memory read data

Behaviour:
- Reset values: all outputs 0; state IDLE; owner=C; starve_cnt=0.
- FSM states:
  - IDLE: mem_req_o = c_req_i | d_req_i.
    - Select D if d_req_i and (!c_req_i or starve_cnt==STARVE_LIMIT); otherwise select C.
    - Request fields are muxed combinationally from the selected port.
    - Handshake = mem_req_o & mem_gnt_i. On handshake: assert the selected x_gnt_o in the same cycle, latch owner, go to BUSY.
  - BUSY: mem_req_o=0; both gnt_o=0.
    - On mem_rvalid_i: route mem_rdata_i to the owner's rdata and pulse owner's rvalid for one cycle (combinational from mem_rvalid_i); go to IDLE.
    - The next request issues the following cycle at the earliest.
- Non-owner rvalid_o is always 0; non-owner rdata_o holds its last value.
- Minimum transaction length is 2 cycles (grant, response).
- Requesters hold req and fields stable until gnt; the arbiter does not check this.
- starve_cnt:
  - In IDLE, increments (saturating at STARVE_LIMIT) each cycle d_req_i=1 and D is not granted.
  - Clears on D grant, or when d_req_i=0.
  - Holds in BUSY.
- Once starve_cnt==STARVE_LIMIT, D stays selected until granted, even if mem_gnt_i is low; selection must not flip mid-handshake.
- Simultaneous c_req_i and d_req_i with starve_cnt<STARVE_LIMIT: C wins.
- mem_rvalid_i in IDLE (stray): ignored, no rvalid_o pulsed; sticky internal flag stray_rsp set (visible only under the feature below).
- mem_gnt_i held low: stay in IDLE, request stays asserted, fields stable for the selected requester.
- Reset mid-BUSY: asynchronously return to IDLE; the outstanding response is dropped and never delivered after reset.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN
- When defined:
  - Adds outputs perf_c_cnt_o and perf_d_cnt_o (32 bit each): granted transactions per port, wrapping at 2^32.
  - Adds perf_stall_o (32 bit): IDLE cycles with a pending request but no handshake.
  - Adds stray_rsp_o (1 bit): sticky stray-response flag.
  - All reset to 0.
- When undefined: these ports and registers are absent; the functional behaviour above is identical.

Decomposition:
- riscv_pkg:
  - XLEN.
  - New typedef dmem_req_t {we, addr, wdata, be}.
  - Enum arb_state_e {ARB_IDLE, ARB_BUSY}.
  - Enum arb_owner_e {OWN_CORE, OWN_DBG}.
- One sub-module, arb_starve_ctr: saturating counter with clear; owns starve_cnt and exposes force_d = (cnt==STARVE_LIMIT).
- FSM, muxing and response routing live in dmem_arbiter.

Test Plan:
- C-only read, addr 0x0000_0010, memory returns 0xDEAD_BEEF after 3 cycles → c_gnt_o at cycle 0, c_rvalid_o one cycle with c_rdata_o=0xDEAD_BEEF, d_rvalid_o stays 0.
- C and D request in the same cycle with starve_cnt=0 → C granted first; D granted in the first IDLE cycle after C's response; each rvalid goes only to its owner.
- C requests every cycle while D holds a request, STARVE_LIMIT=4, mem_gnt_i=1, 1-cycle response → D granted once starve_cnt reaches 4; starve_cnt returns to 0 after D's grant.
- D write, be=4'b0011, data 0x1234_5678, mem_gnt_i low for 5 cycles → mem_req_o high and fields stable for 5 cycles; d_gnt_o only in the handshake cycle; d_rvalid_o on the write ack.
- rstn_i pulsed low while BUSY, then a late mem_rvalid_i → no rvalid_o on either port; outputs 0; a later C read completes normally.
- Stray mem_rvalid_i in IDLE → no response pulse. With DMEM_ARB_PERF_EN defined: stray_rsp_o=1, and after 3 C and 2 D transactions perf_c_cnt_o=3, perf_d_cnt_o=2.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared widths, bus payload and state encodings for the data-memory arbiter.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned BE_W     = XLEN / 8;
    localparam int unsigned STARVE_W = 8;
    localparam int unsigned PERF_W   = 32;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [BE_W-1:0] be;
    } dmem_req_t;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic [0:0] {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating wait counter for the debug port; force_d_c flags that debug must win next.
module arb_starve_ctr
    import riscv_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic force_d_c
);

    localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(LIMIT);

    logic [STARVE_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != LIMIT_C)) begin
            cnt_q <= cnt_q + STARVE_W'(1);
        end
    end

    assign force_d_c = (cnt_q == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core has priority, debug is forced through after a bounded wait.
// Optional performance counters and stray-response flag under `DMEM_ARB_PERF_EN.
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN         = riscv_pkg::XLEN,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            c_req_i,
    input  logic            c_we_i,
    input  logic [XLEN-1:0] c_addr_i,
    input  logic [XLEN-1:0] c_wdata_i,
    input  logic [BE_W-1:0] c_be_i,
    output logic            c_gnt_o,
    output logic            c_rvalid_o,
    output logic [XLEN-1:0] c_rdata_o,
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [XLEN-1:0] d_addr_i,
    input  logic [XLEN-1:0] d_wdata_i,
    input  logic [BE_W-1:0] d_be_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [XLEN-1:0] d_rdata_o,
`ifdef DMEM_ARB_PERF_EN
    output logic [PERF_W-1:0] perf_c_cnt_o,
    output logic [PERF_W-1:0] perf_d_cnt_o,
    output logic [PERF_W-1:0] perf_stall_o,
    output logic              stray_rsp_o,
`endif
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [BE_W-1:0] mem_be_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    arb_state_e      state_q, state_d;
    arb_owner_e      owner_q, owner_d;
    dmem_req_t       c_pkt, d_pkt, sel_pkt;
    logic            sel_d;
    logic            hs;
    logic            force_d;
    logic            starve_inc, starve_clr;
    logic [XLEN-1:0] c_rdata_q, d_rdata_q;

    assign c_pkt = '{we: c_we_i, addr: c_addr_i, wdata: c_wdata_i, be: c_be_i};
    assign d_pkt = '{we: d_we_i, addr: d_addr_i, wdata: d_wdata_i, be: d_be_i};

    // Once force_d is up the counter holds at the limit until D's grant, so selection cannot flip.
    assign sel_d   = d_req_i & (~c_req_i | force_d);
    assign sel_pkt = sel_d ? d_pkt : c_pkt;

    assign mem_we_o    = sel_pkt.we;
    assign mem_addr_o  = sel_pkt.addr;
    assign mem_wdata_o = sel_pkt.wdata;
    assign mem_be_o    = sel_pkt.be;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_CORE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Next state, grants and response routing.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        mem_req_o  = 1'b0;
        hs         = 1'b0;
        c_gnt_o    = 1'b0;
        d_gnt_o    = 1'b0;
        c_rvalid_o = 1'b0;
        d_rvalid_o = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                mem_req_o = c_req_i | d_req_i;
                hs        = mem_req_o & mem_gnt_i;
                c_gnt_o   = hs & ~sel_d;
                d_gnt_o   = hs & sel_d;
                if (hs) begin
                    state_d = ARB_BUSY;
                    owner_d = sel_d ? OWN_DBG : OWN_CORE;
                end
            end
            ARB_BUSY: begin
                if (mem_rvalid_i) begin
                    c_rvalid_o = (owner_q == OWN_CORE);
                    d_rvalid_o = (owner_q == OWN_DBG);
                    state_d    = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Non-owner read data keeps the last value delivered to that port.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (c_rvalid_o) c_rdata_q <= mem_rdata_i;
            if (d_rvalid_o) d_rdata_q <= mem_rdata_i;
        end
    end

    assign c_rdata_o = c_rvalid_o ? mem_rdata_i : c_rdata_q;
    assign d_rdata_o = d_rvalid_o ? mem_rdata_i : d_rdata_q;

    assign starve_inc = (state_q == ARB_IDLE) & d_req_i & ~d_gnt_o;
    assign starve_clr = (state_q == ARB_IDLE) & (~d_req_i | d_gnt_o);

    arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .inc_i    (starve_inc),
        .clr_i    (starve_clr),
        .force_d_c(force_d)
    );

`ifdef DMEM_ARB_PERF_EN
    logic [PERF_W-1:0] perf_c_q, perf_d_q, perf_stall_q;
    logic              stray_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            perf_c_q     <= '0;
            perf_d_q     <= '0;
            perf_stall_q <= '0;
            stray_q      <= 1'b0;
        end else begin
            if (c_gnt_o) perf_c_q <= perf_c_q + PERF_W'(1);
            if (d_gnt_o) perf_d_q <= perf_d_q + PERF_W'(1);
            if (mem_req_o && !hs) perf_stall_q <= perf_stall_q + PERF_W'(1);
            if ((state_q == ARB_IDLE) && mem_rvalid_i) stray_q <= 1'b1;
        end
    end

    assign perf_c_cnt_o = perf_c_q;
    assign perf_d_cnt_o = perf_d_q;
    assign perf_stall_o = perf_stall_q;
    assign stray_rsp_o  = stray_q;
`endif

endmodule
